// File: rtl/core_pkg.sv
// Shared core constants and types for the integer register file slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default data width, default register count, register address type, zero-register index.
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back or flush.
// Latency: set/clear visible 1 cycle after the edge; busy lookup is combinational.
// Backpressure: none; producers are never stalled, issue consumes busy to stall itself.
// Ports: clk/rst (sync, active-high); iss_en/iss_rd marks a producer; wb0/wb1 en+addr clear;
//        flush clears all; rsN_addr + rsN_hit (bypass already gated) give rsN_busy.
import core_pkg::*;

module regfile_sb_scoreboard #(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rd,
  input  logic          wb0_en,
  input  logic [AW-1:0] wb0_addr,
  input  logic          wb1_en,
  input  logic [AW-1:0] wb1_addr,
  input  logic          flush,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          rs1_hit,
  input  logic          rs2_hit,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  // Clears first, then the issue set, so a new producer survives a
  // write-back from the old producer of the same register.
  always_comb begin
    pending_nxt = pending;
    if (wb0_en) pending_nxt[wb0_addr] = 1'b0;
    if (wb1_en) pending_nxt[wb1_addr] = 1'b0;
    if (iss_en && (iss_rd != ZERO_ADDR)) pending_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // pending[0] is never set, so x0 can never report busy.
  assign rs1_busy = pending[rs1_addr] & ~rs1_hit;
  assign rs2_busy = pending[rs2_addr] & ~rs2_hit;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: 2 combinational read ports, 2 write-back ports, x0 hardwired, optional bypass, RAW scoreboard.
// Latency: reads 0 cycles; writes and pending updates 1 cycle.
// Backpressure: none; write-back ports are always accepted, issue stalls itself on rsN_busy.
// Ports: clk/rst (sync, active-high); rsN_addr -> rsN_data/rsN_busy; iss_en/iss_rd mark a producer;
//        wb0 (ALU) and wb1 (load/long-latency) en/addr/data write back, wb1 wins a same-register tie;
//        flush clears all pending bits.
import core_pkg::*;

module regfile_sb #(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  input  logic            flush
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREGS];

  // wb1 is applied after wb0 so it wins a same-register collision.
  // Flush does not gate writes: squashing only affects the scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wb0_en && (wb0_addr != ZERO_ADDR)) regs[wb0_addr] <= wb0_data;
      if (wb1_en && (wb1_addr != ZERO_ADDR)) regs[wb1_addr] <= wb1_data;
    end
  end

  // Hits are qualified by BYPASS here so both the data mux and the busy
  // suppression see the same decision.
  logic rs1_hit0, rs1_hit1, rs2_hit0, rs2_hit1;
  logic rs1_hit, rs2_hit;

  assign rs1_hit0 = BYPASS && wb0_en && (wb0_addr == rs1_addr) && (rs1_addr != ZERO_ADDR);
  assign rs1_hit1 = BYPASS && wb1_en && (wb1_addr == rs1_addr) && (rs1_addr != ZERO_ADDR);
  assign rs2_hit0 = BYPASS && wb0_en && (wb0_addr == rs2_addr) && (rs2_addr != ZERO_ADDR);
  assign rs2_hit1 = BYPASS && wb1_en && (wb1_addr == rs2_addr) && (rs2_addr != ZERO_ADDR);
  assign rs1_hit  = rs1_hit0 | rs1_hit1;
  assign rs2_hit  = rs2_hit0 | rs2_hit1;

  always_comb begin
    rs1_data = '0;
    if (rs1_hit1) begin
      rs1_data = wb1_data;
    end else if (rs1_hit0) begin
      rs1_data = wb0_data;
    end else if (rs1_addr != ZERO_ADDR) begin
      rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_hit1) begin
      rs2_data = wb1_data;
    end else if (rs2_hit0) begin
      rs2_data = wb0_data;
    end else if (rs2_addr != ZERO_ADDR) begin
      rs2_data = regs[rs2_addr];
    end
  end

  regfile_sb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wb0_en   (wb0_en),
    .wb0_addr (wb0_addr),
    .wb1_en   (wb1_en),
    .wb1_addr (wb1_addr),
    .flush    (flush),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance driven by the same inputs.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, iss_rd, wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        iss_en, wb0_en, wb1_en, flush;

  logic [31:0] rs1_data, rs2_data, n_rs1_data, n_rs2_data;
  logic        rs1_busy, rs2_busy, n_rs1_busy, n_rs2_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .flush(flush)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
    .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop all strobes.
  task automatic tick();
    @(posedge clk);
    #2;
    iss_en = 1'b0;
    wb0_en = 1'b0;
    wb1_en = 1'b0;
    flush  = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iss_en = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0; flush = 1'b0;
    rs1_addr = 5'd1; rs2_addr = 5'd2; iss_rd = 5'd0;
    wb0_addr = 5'd0; wb1_addr = 5'd0; wb0_data = '0; wb1_data = '0;
    @(posedge clk);
    tick();
    #1;
    chk("reset_init_rs1_data", rs1_data, 32'h0);
    chk("reset_init_rs1_busy", {31'b0, rs1_busy}, 32'h0);

    // Fill x1, x2 and mark x3 pending.
    wb0_en = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h0000_0011;
    wb1_en = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h0000_0022;
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    chk("fill_x1", rs1_data, 32'h11);
    chk("fill_x2", rs2_data, 32'h22);
    rs1_addr = 5'd3; #1;
    chk("fill_x3_busy", {31'b0, rs1_busy}, 32'h1);

    // Reset cycle with a write and an issue that must be ignored.
    rst = 1'b1;
    wb0_en = 1'b1; wb0_addr = 5'd4; wb0_data = 32'hFF;
    iss_en = 1'b1; iss_rd = 5'd5;
    tick();
    rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    chk("rst_x1_data", rs1_data, 32'h0);
    chk("rst_x2_data", rs2_data, 32'h0);
    rs1_addr = 5'd3; rs2_addr = 5'd5; #1;
    chk("rst_x3_busy", {31'b0, rs1_busy}, 32'h0);
    chk("rst_x5_busy_ignored_issue", {31'b0, rs2_busy}, 32'h0);
    rs1_addr = 5'd4; #1;
    chk("rst_x4_write_ignored", rs1_data, 32'h0);

    // x0: write and issue to x0 are discarded.
    wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hDEAD_BEEF;
    iss_en = 1'b1; iss_rd = 5'd0;
    rs1_addr = 5'd0; #1;
    chk("x0_same_cycle_data", rs1_data, 32'h0);
    chk("x0_same_cycle_busy", {31'b0, rs1_busy}, 32'h0);
    tick();
    #1;
    chk("x0_next_data", rs1_data, 32'h0);
    chk("x0_next_busy", {31'b0, rs1_busy}, 32'h0);

    // Bypass of wb0 into rs1 (x5 not pending: legal write, stays non-busy).
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h1234_5678;
    rs1_addr = 5'd5; #1;
    chk("byp_same_cycle", rs1_data, 32'h1234_5678);
    chk("nobyp_same_cycle_old", n_rs1_data, 32'h0);
    tick();
    #1;
    chk("nobyp_next_cycle", n_rs1_data, 32'h1234_5678);
    chk("byp_next_cycle", rs1_data, 32'h1234_5678);
    chk("x5_nonpending_busy", {31'b0, rs1_busy}, 32'h0);

    // Same-register write conflict: wb1 wins.
    wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1;
    wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h2;
    rs1_addr = 5'd7; #1;
    chk("conflict_same_cycle", rs1_data, 32'h2);
    tick();
    #1;
    chk("conflict_next", rs1_data, 32'h2);
    chk("conflict_next_nobyp", n_rs1_data, 32'h2);

    // Scoreboard on x9.
    iss_en = 1'b1; iss_rd = 5'd9;
    rs2_addr = 5'd9; #1;
    chk("sb_issue_same_cycle_busy", {31'b0, rs2_busy}, 32'h0);
    tick();
    #1;
    chk("sb_busy_after_issue", {31'b0, rs2_busy}, 32'h1);
    chk("sb_busy_after_issue_nobyp", {31'b0, n_rs2_busy}, 32'h1);
    wb1_en = 1'b1; wb1_addr = 5'd9; wb1_data = 32'hA5; #1;
    chk("sb_wb_hit_busy", {31'b0, rs2_busy}, 32'h0);
    chk("sb_wb_hit_data", rs2_data, 32'hA5);
    chk("sb_wb_nobyp_busy", {31'b0, n_rs2_busy}, 32'h1);
    chk("sb_wb_nobyp_data", n_rs2_data, 32'h0);
    tick();
    #1;
    chk("sb_cleared_busy", {31'b0, rs2_busy}, 32'h0);
    chk("sb_cleared_data", rs2_data, 32'hA5);

    // Issue and write-back of x9 in the same cycle: issue wins.
    iss_en = 1'b1; iss_rd = 5'd9;
    wb0_en = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h5A;
    tick();
    #1;
    chk("sb_issue_over_wb_busy", {31'b0, rs2_busy}, 32'h1);
    chk("sb_issue_over_wb_data", rs2_data, 32'h5A);
    wb1_en = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h77;
    tick();
    #1;
    chk("sb_final_clear_busy", {31'b0, rs2_busy}, 32'h0);

    // Flush with a concurrent issue.
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    iss_en = 1'b1; iss_rd = 5'd4;
    tick();
    rs1_addr = 5'd3; rs2_addr = 5'd4; #1;
    chk("fl_pre_x3_busy", {31'b0, rs1_busy}, 32'h1);
    chk("fl_pre_x4_busy", {31'b0, rs2_busy}, 32'h1);
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd6;
    wb0_en = 1'b1; wb0_addr = 5'd10; wb0_data = 32'hCAFE;
    tick();
    #1;
    chk("fl_x3_busy", {31'b0, rs1_busy}, 32'h0);
    chk("fl_x4_busy", {31'b0, rs2_busy}, 32'h0);
    rs1_addr = 5'd6; rs2_addr = 5'd10; #1;
    chk("fl_x6_busy", {31'b0, rs1_busy}, 32'h0);
    chk("fl_write_commits", rs2_data, 32'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
